// File: rtl/decode_stage_pipe_if.sv
// Decode-stage bundle: every signal between the hazard/writeback logic and the
// decode stage, apart from clock and reset.
//   slave  : decode stage side (takes D/W/hazard inputs, drives D and E outputs)
//   master : driving side (drives D/W/hazard inputs, observes D and E outputs)
// Signals:
//   inst_D, valid_D, imm_mode_D         instruction in D, its valid bit, imm mode
//   reg_write_W, reg_id_W, result_W     writeback port
//   hold_E, flush_E                     D/E register control from the hazard unit
//   rs_out_D, rt_out_D                  combinational bypassed operands
//   rs_out_E, rt_out_E, imm_E           registered operands and immediate
//   rs_id_E, rt_id_E, rd_id_E, valid_E  registered register fields and valid
interface decode_stage_pipe_if #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
);
  localparam int AW = $clog2(NREGS);

  logic [31:0]       inst_D;
  logic              valid_D;
  logic [1:0]        imm_mode_D;
  logic              reg_write_W;
  logic [AW-1:0]     reg_id_W;
  logic [DATA_W-1:0] result_W;
  logic              hold_E;
  logic              flush_E;
  logic [DATA_W-1:0] rs_out_D;
  logic [DATA_W-1:0] rt_out_D;
  logic [DATA_W-1:0] rs_out_E;
  logic [DATA_W-1:0] rt_out_E;
  logic [DATA_W-1:0] imm_E;
  logic [4:0]        rs_id_E;
  logic [4:0]        rt_id_E;
  logic [4:0]        rd_id_E;
  logic              valid_E;

  modport slave (
    input  inst_D, valid_D, imm_mode_D, reg_write_W, reg_id_W, result_W,
           hold_E, flush_E,
    output rs_out_D, rt_out_D, rs_out_E, rt_out_E, imm_E,
           rs_id_E, rt_id_E, rd_id_E, valid_E
  );

  modport master (
    output inst_D, valid_D, imm_mode_D, reg_write_W, reg_id_W, result_W,
           hold_E, flush_E,
    input  rs_out_D, rt_out_D, rs_out_E, rt_out_E, imm_E,
           rs_id_E, rt_id_E, rd_id_E, valid_E
  );
endinterface

// File: rtl/decode_stage_pipe.sv
// Decode stage of the pipelined MIPS core with its D/E pipeline register.
// Holds the architectural register file, bypasses a same-cycle writeback into
// the D operands, extends the immediate and registers everything into E.
// Ports:
//   clk    clock, all state updates on posedge
//   reset  asynchronous active-high reset; clears register file and E outputs
//   bus    decode_stage_pipe_if.slave (see interface header for the signals)
module decode_stage_pipe #(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  decode_stage_pipe_if.slave   bus
);
  localparam int AW = $clog2(NREGS);
  localparam bit ZR = (ZERO_REG != 0);

  // Instruction fields
  logic [4:0]    rs_fld, rt_fld, rd_fld;
  logic [15:0]   imm_fld;
  logic [AW-1:0] rs_idx, rt_idx;
  logic          unused_opcode;

  assign rs_fld        = bus.inst_D[25:21];
  assign rt_fld        = bus.inst_D[20:16];
  assign rd_fld        = bus.inst_D[15:11];
  assign imm_fld       = bus.inst_D[15:0];
  assign rs_idx        = rs_fld[AW-1:0];
  assign rt_idx        = rt_fld[AW-1:0];
  assign unused_opcode = ^bus.inst_D[31:26];

  // Register file
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  wr_en;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_wr_en
      // Register 0 is hard-wired to zero when ZR is set, so it never loads.
      assign wr_en[gi] = bus.reg_write_W && (bus.reg_id_W == AW'(gi)) &&
                         !(ZR && gi == 0);
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        if (wr_en[i]) regs_q[i] <= bus.result_W;
    end
  end

  // Read with write-through: a live W write to the same index wins over the
  // array, so D never sees a stale value and no W->D hazard exists.
  logic rs_zero, rt_zero, rs_live, rt_live;
  logic [DATA_W-1:0] rs_val, rt_val;

  assign rs_zero = ZR && (rs_idx == '0);
  assign rt_zero = ZR && (rt_idx == '0);
  assign rs_live = bus.reg_write_W && (bus.reg_id_W == rs_idx) && !rs_zero;
  assign rt_live = bus.reg_write_W && (bus.reg_id_W == rt_idx) && !rt_zero;
  assign rs_val  = rs_zero ? '0 : (rs_live ? bus.result_W : regs_q[rs_idx]);
  assign rt_val  = rt_zero ? '0 : (rt_live ? bus.result_W : regs_q[rt_idx]);

  assign bus.rs_out_D = rs_val;
  assign bus.rt_out_D = rt_val;

  // Immediate extension. Replication counts are kept >= 1 so DATA_W == 32
  // does not produce a zero-width replication.
  logic [31:0]       upper32;
  logic [DATA_W-1:0] imm_ext;

  assign upper32 = {imm_fld, 16'h0000};

  always_comb begin
    imm_ext = {{(DATA_W-15){imm_fld[15]}}, imm_fld[14:0]};
    case (bus.imm_mode_D)
      2'b01:   imm_ext = {{(DATA_W-16){1'b0}}, imm_fld};
      2'b10:   imm_ext = {{(DATA_W-31){upper32[31]}}, upper32[30:0]};
      default: imm_ext = {{(DATA_W-15){imm_fld[15]}}, imm_fld[14:0]};
    endcase
  end

  // D/E register
  logic [DATA_W-1:0] rs_out_q, rs_out_d, rt_out_q, rt_out_d, imm_q, imm_d;
  logic [4:0]        rs_id_q, rs_id_d, rt_id_q, rt_id_d, rd_id_q, rd_id_d;
  logic              valid_q, valid_d;
  logic [AW-1:0]     rs_held_idx, rt_held_idx;
  logic              rs_held_live, rt_held_live;

  // While held, the E operands track W writes to their own registers so a long
  // stall cannot leave them stale.
  assign rs_held_idx  = rs_id_q[AW-1:0];
  assign rt_held_idx  = rt_id_q[AW-1:0];
  assign rs_held_live = bus.reg_write_W && (bus.reg_id_W == rs_held_idx) &&
                        !(ZR && rs_held_idx == '0);
  assign rt_held_live = bus.reg_write_W && (bus.reg_id_W == rt_held_idx) &&
                        !(ZR && rt_held_idx == '0);

  always_comb begin
    rs_out_d = rs_out_q;
    rt_out_d = rt_out_q;
    imm_d    = imm_q;
    rs_id_d  = rs_id_q;
    rt_id_d  = rt_id_q;
    rd_id_d  = rd_id_q;
    valid_d  = valid_q;
    if (bus.flush_E) begin
      rs_out_d = '0;
      rt_out_d = '0;
      imm_d    = '0;
      rs_id_d  = '0;
      rt_id_d  = '0;
      rd_id_d  = '0;
      valid_d  = 1'b0;
    end else if (bus.hold_E) begin
      if (rs_held_live) rs_out_d = bus.result_W;
      if (rt_held_live) rt_out_d = bus.result_W;
    end else begin
      // Bubbles are captured too; valid_E marks them.
      rs_out_d = rs_val;
      rt_out_d = rt_val;
      imm_d    = imm_ext;
      rs_id_d  = rs_fld;
      rt_id_d  = rt_fld;
      rd_id_d  = rd_fld;
      valid_d  = bus.valid_D;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_out_q <= '0;
      rt_out_q <= '0;
      imm_q    <= '0;
      rs_id_q  <= '0;
      rt_id_q  <= '0;
      rd_id_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      rs_out_q <= rs_out_d;
      rt_out_q <= rt_out_d;
      imm_q    <= imm_d;
      rs_id_q  <= rs_id_d;
      rt_id_q  <= rt_id_d;
      rd_id_q  <= rd_id_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.rs_out_E = rs_out_q;
  assign bus.rt_out_E = rt_out_q;
  assign bus.imm_E    = imm_q;
  assign bus.rs_id_E  = rs_id_q;
  assign bus.rt_id_E  = rt_id_q;
  assign bus.rd_id_E  = rd_id_q;
  assign bus.valid_E  = valid_q;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe. Two instances share one stimulus:
// dut_z has register 0 hard-wired to zero, dut_n treats it as ordinary.
module tb_decode_stage_pipe;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  decode_stage_pipe_if #(.DATA_W(32), .NREGS(32)) bus_z ();
  decode_stage_pipe_if #(.DATA_W(32), .NREGS(32)) bus_n ();

  decode_stage_pipe #(.DATA_W(32), .NREGS(32), .ZERO_REG(1)) dut_z (
    .clk(clk), .reset(reset), .bus(bus_z.slave));
  decode_stage_pipe #(.DATA_W(32), .NREGS(32), .ZERO_REG(0)) dut_n (
    .clk(clk), .reset(reset), .bus(bus_n.slave));

  // Second instance mirrors the inputs of the first
  assign bus_n.inst_D      = bus_z.inst_D;
  assign bus_n.valid_D     = bus_z.valid_D;
  assign bus_n.imm_mode_D  = bus_z.imm_mode_D;
  assign bus_n.reg_write_W = bus_z.reg_write_W;
  assign bus_n.reg_id_W    = bus_z.reg_id_W;
  assign bus_n.result_W    = bus_z.result_W;
  assign bus_n.hold_E      = bus_z.hold_E;
  assign bus_n.flush_E     = bus_z.flush_E;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end else begin
      $display("ok   %s = %08h", tag, got);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
    return {6'h00, rs, rt, imm};
  endfunction

  task automatic drive(input logic [31:0] inst, input logic vld, input logic [1:0] mode,
                       input logic we, input logic [4:0] wid, input logic [31:0] wdata,
                       input logic hold, input logic flush);
    bus_z.inst_D      = inst;
    bus_z.valid_D     = vld;
    bus_z.imm_mode_D  = mode;
    bus_z.reg_write_W = we;
    bus_z.reg_id_W    = wid;
    bus_z.result_W    = wdata;
    bus_z.hold_E      = hold;
    bus_z.flush_E     = flush;
    #1;
  endtask

  // Advance one clock and settle on the falling edge for sampling
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_e(input string tag, input logic [31:0] rs_e, input logic [31:0] rt_e,
                         input logic [31:0] imm, input logic [4:0] rs_id, input logic [4:0] rt_id,
                         input logic [4:0] rd_id, input logic vld);
    check_val({tag, ".rs_out_E"}, bus_z.rs_out_E, rs_e);
    check_val({tag, ".rt_out_E"}, bus_z.rt_out_E, rt_e);
    check_val({tag, ".imm_E"},    bus_z.imm_E, imm);
    check_val({tag, ".rs_id_E"},  {27'd0, bus_z.rs_id_E}, {27'd0, rs_id});
    check_val({tag, ".rt_id_E"},  {27'd0, bus_z.rt_id_E}, {27'd0, rt_id});
    check_val({tag, ".rd_id_E"},  {27'd0, bus_z.rd_id_E}, {27'd0, rd_id});
    check_val({tag, ".valid_E"},  {31'd0, bus_z.valid_E}, {31'd0, vld});
  endtask

  initial begin
    reset = 1'b1;
    drive(32'h0, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    reset = 1'b0;
    #1;

    // Reset state: every register reads zero, E outputs cleared
    for (int i = 0; i < 4; i++) begin
      drive(mk_inst(5'(i * 9), 5'(31 - i * 7), 16'h0), 1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      check_val($sformatf("rst.rs_out_D[%0d]", i), bus_z.rs_out_D, 32'h0);
      check_val($sformatf("rst.rt_out_D[%0d]", i), bus_z.rt_out_D, 32'h0);
    end
    check_e("rst", 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);

    // Write r5 and read it in the same cycle through the bypass
    drive(mk_inst(5'd5, 5'd0, 16'h1803), 1'b1, 2'b00, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check_val("wt.rs_out_D", bus_z.rs_out_D, 32'hDEAD_BEEF);
    check_val("wt.rt_out_D", bus_z.rt_out_D, 32'h0);
    step();
    check_e("wt", 32'hDEAD_BEEF, 32'h0, 32'h0000_1803, 5'd5, 5'd0, 5'd3, 1'b1);

    // r5 now comes from the array
    drive(mk_inst(5'd1, 5'd5, 16'h0), 1'b1, 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    check_val("arr.rt_out_D", bus_z.rt_out_D, 32'hDEAD_BEEF);
    check_val("arr.rs_out_D", bus_z.rs_out_D, 32'h0);
    step();

    // Register 0 write: discarded with ZERO_REG=1, kept with ZERO_REG=0
    drive(mk_inst(5'd0, 5'd0, 16'h0), 1'b1, 2'b00, 1'b1, 5'd0, 32'h0000_1234, 1'b0, 1'b0);
    check_val("r0z.same_D", bus_z.rs_out_D, 32'h0);
    check_val("r0n.same_D", bus_n.rs_out_D, 32'h0000_1234);
    step();
    check_val("r0z.rs_out_E", bus_z.rs_out_E, 32'h0);
    check_val("r0n.rs_out_E", bus_n.rs_out_E, 32'h0000_1234);
    drive(mk_inst(5'd0, 5'd0, 16'h0), 1'b1, 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    check_val("r0z.later_D", bus_z.rt_out_D, 32'h0);
    check_val("r0n.later_D", bus_n.rt_out_D, 32'h0000_1234);
    step();

    // Immediate modes with imm = 8001
    drive(mk_inst(5'd0, 5'd0, 16'h8001), 1'b1, 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    step();
    check_val("imm.sext", bus_z.imm_E, 32'hFFFF_8001);
    drive(mk_inst(5'd0, 5'd0, 16'h8001), 1'b1, 2'b01, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    step();
    check_val("imm.zext", bus_z.imm_E, 32'h0000_8001);
    drive(mk_inst(5'd0, 5'd0, 16'h8001), 1'b1, 2'b10, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    step();
    check_val("imm.upper", bus_z.imm_E, 32'h8001_0000);
    drive(mk_inst(5'd0, 5'd0, 16'h8001), 1'b1, 2'b11, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    step();
    check_val("imm.mode3", bus_z.imm_E, 32'hFFFF_8001);

    // Hold: capture rs=7, rt=5, rd=9, then stall three cycles with W refreshes
    drive(mk_inst(5'd7, 5'd5, 16'h4800), 1'b1, 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    step();
    check_e("hold0", 32'h0, 32'hDEAD_BEEF, 32'h0000_4800, 5'd7, 5'd5, 5'd9, 1'b1);
    drive(mk_inst(5'd1, 5'd2, 16'hFFFF), 1'b0, 2'b01, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    step();
    check_e("hold1", 32'h0, 32'hDEAD_BEEF, 32'h0000_4800, 5'd7, 5'd5, 5'd9, 1'b1);
    drive(mk_inst(5'd1, 5'd2, 16'hFFFF), 1'b0, 2'b01, 1'b1, 5'd7, 32'h0000_0055, 1'b1, 1'b0);
    step();
    check_e("hold2", 32'h0000_0055, 32'hDEAD_BEEF, 32'h0000_4800, 5'd7, 5'd5, 5'd9, 1'b1);
    drive(mk_inst(5'd1, 5'd2, 16'hFFFF), 1'b0, 2'b01, 1'b1, 5'd5, 32'h0000_0066, 1'b1, 1'b0);
    step();
    check_e("hold3", 32'h0000_0055, 32'h0000_0066, 32'h0000_4800, 5'd7, 5'd5, 5'd9, 1'b1);

    // Flush wins over hold
    drive(mk_inst(5'd7, 5'd5, 16'h4800), 1'b1, 2'b00, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
    step();
    check_e("flush", 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);

    // Bubble is still captured; r5 holds the value written during the hold
    drive(mk_inst(5'd5, 5'd7, 16'h0002), 1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    step();
    check_e("bubble", 32'h0000_0066, 32'h0000_0055, 32'h0000_0002, 5'd5, 5'd7, 5'd0, 1'b0);

    // Asynchronous reset mid-stream, checked before the next rising edge
    drive(mk_inst(5'd5, 5'd7, 16'h7FFF), 1'b1, 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    step();
    check_val("pre_rst.valid_E", {31'd0, bus_z.valid_E}, 32'd1);
    drive(mk_inst(5'd5, 5'd7, 16'h7FFF), 1'b1, 2'b00, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    check_e("arst", 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    check_val("arst.rs_out_D", bus_z.rs_out_D, 32'h0);
    check_val("arst.rt_out_D", bus_z.rt_out_D, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // First edge after reset captures normally
    drive(mk_inst(5'd5, 5'd7, 16'h7FFF), 1'b1, 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    step();
    check_e("post_rst", 32'h0, 32'h0, 32'h0000_7FFF, 5'd5, 5'd7, 5'd15, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
